datamem_read_arbiter: RTL and testbench

- Sequences burst reads from the 128-word x 32-bit data memory on behalf of two requesters, sharing the memory's single read port.
- Each request names a base word address and a burst length.
- The block drives the memory's load/address inputs and registers each returned word.
- Words are delivered on a valid/ready response channel, tagged with requester id and a last-word flag.
- Fairness between requesters is round-robin.

---
 rtl/datamem_read_arbiter.sv | 142 ++++++++++++++
 tb/tb_datamem_read_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/datamem_read_arbiter.sv
// Round-robin burst-read sequencer for two requesters sharing the single read
// port of a 128 x 32 data memory; each word is returned on a valid/ready channel.
module datamem_read_arbiter #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [LEN_W-1:0]  req0_len,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [LEN_W-1:0]  req1_len,
  output logic              req1_ready,
  output logic              mem_load,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_id,
  output logic              rsp_last,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]    remaining_q, remaining_d;
  logic                id_q, id_d;
  logic                last_grant_q, last_grant_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_id_q, rsp_id_d;
  logic                rsp_last_q, rsp_last_d;

  logic                grant_any;
  logic                grant_id;
  logic                accept;
  logic [ADDR_W-1:0]   sel_addr;
  logic [LEN_W-1:0]    sel_len;

  // Both pending: the one not served last time wins; otherwise whoever asks.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    if (req0_valid && req1_valid) grant_id = ~last_grant_q;
    else                          grant_id = ~req0_valid;
    sel_addr = grant_id ? req1_addr : req0_addr;
    sel_len  = grant_id ? req1_len  : req0_len;
    accept   = (state_q == IDLE) && grant_any && !reset;
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cur_addr_q   <= '0;
      remaining_q  <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= 1'b0;
      rsp_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      remaining_q  <= remaining_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      rsp_last_q   <= rsp_last_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    remaining_d  = remaining_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    rsp_last_d   = rsp_last_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          // Memory is only 128 deep, so the top address bit is forced low.
          cur_addr_d   = {1'b0, sel_addr[ADDR_W-2:0]};
          remaining_d  = sel_len;
          id_d         = grant_id;
          last_grant_d = grant_id;
          state_d      = READ;
        end
      end
      READ: begin
        rsp_data_d  = mem_data;
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_last_d  = (remaining_q == '0);
        state_d     = HOLD;
      end
      HOLD: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (remaining_q == '0) begin
            rsp_last_d = 1'b0;
            state_d    = IDLE;
          end else begin
            // Low bits wrap naturally from 127 back to 0.
            cur_addr_d  = {1'b0, cur_addr_q[ADDR_W-2:0] + (ADDR_W-1)'(1)};
            remaining_d = remaining_q - LEN_W'(1);
            state_d     = READ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    mem_load    = (state_q == READ);
    mem_address = (state_q == READ) ? cur_addr_q : '0;
    busy        = (state_q != IDLE);
    req0_ready  = accept && !grant_id && req0_valid;
    req1_ready  = accept &&  grant_id && req1_valid;
    rsp_valid   = rsp_valid_q;
    rsp_data    = rsp_data_q;
    rsp_id      = rsp_id_q;
    rsp_last    = rsp_last_q;
  end

endmodule

// File: tb/tb_datamem_read_arbiter.sv
// Directed bench for datamem_read_arbiter: a behavioural 128-word memory and
// hand-derived expectations for grants, burst data, wrap, backpressure and reset.
module tb_datamem_read_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [7:0]  req0_addr, req1_addr;
  logic [3:0]  req0_len, req1_len;
  logic        req0_ready, req1_ready;
  logic        mem_load;
  logic [7:0]  mem_address;
  logic [31:0] mem_data;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_id, rsp_last, busy;

  logic [31:0] mem [128];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  assign mem_data = mem_load ? mem[mem_address[6:0]] : 32'h0;

  datamem_read_arbiter dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_len(req0_len), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_len(req1_len), .req1_ready(req1_ready),
    .mem_load(mem_load), .mem_address(mem_address), .mem_data(mem_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_last(rsp_last), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Request already presented in IDLE; follows the burst with rsp_ready high.
  task automatic do_burst(input logic id, input int addr, input int len, input bit drop);
    int a;
    int busy_cnt;
    a = addr % 128;
    busy_cnt = 0;
    #1;
    check("grant_rdy", id ? req1_ready : req0_ready, 1);
    check("other_rdy", id ? req0_ready : req1_ready, 0);
    cyc();
    if (drop) begin
      if (id) req1_valid = 1'b0;
      else    req0_valid = 1'b0;
    end
    for (int w = 0; w <= len; w++) begin
      check("rd_load", mem_load, 1);
      check("rd_addr", mem_address, a);
      check("rd_rspv", rsp_valid, 0);
      check("rd_rdy", {req0_ready, req1_ready}, 0);
      busy_cnt += busy;
      cyc();
      check("rsp_valid", rsp_valid, 1);
      check("rsp_data", rsp_data, mem[a]);
      check("rsp_id", rsp_id, id);
      check("rsp_last", rsp_last, (w == len));
      check("hold_load", mem_load, 0);
      busy_cnt += busy;
      cyc();
      a = (a + 1) % 128;
    end
    check("busy_cycles", busy_cnt, 2 * (len + 1));
    check("end_busy", busy, 0);
    check("end_rspv", rsp_valid, 0);
    $display("burst id=%0d addr=%0d len=%0d words=%0d", id, addr, len, len + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    for (int i = 0; i < 128; i++) begin
      b = 8'(i);
      mem[i] = {b, b ^ 8'h5A, ~b, b + 8'h33};
    end
    mem[5] = 32'hA1B2C3D4;

    reset = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_addr = '0; req0_len = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_len = '0;
    cyc(); cyc(); cyc();
    reset = 1'b0;
    #1;
    check("rst_rspv", rsp_valid, 0);
    check("rst_data", rsp_data, 0);
    check("rst_id", rsp_id, 0);
    check("rst_last", rsp_last, 0);
    check("rst_load", mem_load, 0);
    check("rst_addr", mem_address, 0);
    check("rst_busy", busy, 0);
    $display("reset done");

    // Single word from req0
    req0_valid = 1'b1; req0_addr = 8'd5; req0_len = 4'd0;
    do_burst(1'b0, 5, 0, 1'b1);

    // Four-word burst from req1
    req1_valid = 1'b1; req1_addr = 8'd10; req1_len = 4'd3;
    do_burst(1'b1, 10, 3, 1'b1);

    // Round-robin with both requesters continuously valid after reset
    reset = 1'b1; cyc(); reset = 1'b0;
    req0_valid = 1'b1; req0_addr = 8'd20; req0_len = 4'd0;
    req1_valid = 1'b1; req1_addr = 8'd30; req1_len = 4'd0;
    do_burst(1'b0, 20, 0, 1'b0);
    do_burst(1'b1, 30, 0, 1'b0);
    do_burst(1'b0, 20, 0, 1'b0);
    do_burst(1'b1, 30, 0, 1'b1);
    req0_valid = 1'b0;

    // Wrap past 127, with address bit 7 set on input (254 -> 126)
    req0_valid = 1'b1; req0_addr = 8'd254; req0_len = 4'd3;
    do_burst(1'b0, 254, 3, 1'b1);

    // Backpressure: two-word burst, consumer stalls the first word
    req1_valid = 1'b1; req1_addr = 8'd40; req1_len = 4'd1;
    #1;
    check("bp_grant", req1_ready, 1);
    cyc();
    req1_valid = 1'b0; rsp_ready = 1'b0;
    check("bp_rd_load", mem_load, 1);
    check("bp_rd_addr", mem_address, 40);
    cyc();
    check("bp_rspv0", rsp_valid, 1);
    check("bp_data0", rsp_data, mem[40]);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("bp_valid", rsp_valid, 1);
      check("bp_data", rsp_data, mem[40]);
      check("bp_id", rsp_id, 1);
      check("bp_last", rsp_last, 0);
      check("bp_load", mem_load, 0);
    end
    rsp_ready = 1'b1;
    cyc();
    check("bp_rd2_load", mem_load, 1);
    check("bp_rd2_addr", mem_address, 41);
    check("bp_rd2_rspv", rsp_valid, 0);
    cyc();
    check("bp_rspv1", rsp_valid, 1);
    check("bp_data1", rsp_data, mem[41]);
    check("bp_last1", rsp_last, 1);
    cyc();
    check("bp_end_busy", busy, 0);
    $display("burst id=1 addr=40 len=1 words=2 stalled");

    // Reset during HOLD of word 2 of 4
    req0_valid = 1'b1; req0_addr = 8'd50; req0_len = 4'd3;
    #1;
    check("ra_grant", req0_ready, 1);
    cyc();
    req0_valid = 1'b0;
    cyc(); cyc(); cyc();
    check("ra_rspv", rsp_valid, 1);
    check("ra_data", rsp_data, mem[51]);
    reset = 1'b1;
    req0_valid = 1'b1; req0_addr = 8'd60; req0_len = 4'd0;
    req1_valid = 1'b1; req1_addr = 8'd70; req1_len = 4'd0;
    cyc();
    check("ra_rst_rspv", rsp_valid, 0);
    check("ra_rst_busy", busy, 0);
    check("ra_rst_load", mem_load, 0);
    check("ra_rst_data", rsp_data, 0);
    check("ra_rst_last", rsp_last, 0);
    check("ra_rst_rdy", {req0_ready, req1_ready}, 0);
    reset = 1'b0;
    $display("reset abort done");
    do_burst(1'b0, 60, 0, 1'b1);
    do_burst(1'b1, 70, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
